// File: rtl/dht11_scheduler_pkg.sv
// Shared types and helpers for the DHT11 read scheduler: FSM state encoding and tick sizing.
package dht11_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_EVAL      = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    function automatic int tick_1ms_count(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dht11_scheduler_tick_gen_1ms.sv
// Free-running divider producing a one-cycle pulse every millisecond of system clock.
module tick_gen_1ms
    import dht11_scheduler_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = tick_1ms_count(CLK_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_scheduler.sv
// DHT11 read scheduler: launches reads (periodic / on request), enforces the settle gap,
// supervises completion with a watchdog, retries failed reads and holds the last good reading.
module dht11_scheduler
    import dht11_scheduler_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PERIOD_MS  = 2000,
    parameter int MIN_GAP_MS = 1000,
    parameter int TIMEOUT_MS = 50,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req,
    output logic        sensor_start,
    output logic        sensor_rst,
    input  logic        sensor_done,
    input  logic        sensor_valid,
    input  logic [15:0] sensor_hum,
    input  logic [15:0] sensor_temp,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        data_valid,
    output logic        update,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic        err_fail,
    output logic        busy,
    output logic [2:0]  state
);

    localparam int CNT_W = $clog2(max3(PERIOD_MS, MIN_GAP_MS, TIMEOUT_MS) + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(MIN_GAP_MS - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_MS - 1);
    localparam logic [RTY_W-1:0] RTY_LAST    = RTY_W'(MAX_RETRY);

    logic tick;

    tick_gen_1ms #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_nxt, to_cnt, to_nxt, period_cnt, period_nxt;
    logic [RTY_W-1:0] retry_cnt, retry_nxt;
    logic             req_pending, req_pending_nxt, retry_pending, retry_pending_nxt;
    logic             done_q, done_edge, cap;
    logic             rst_two;
    logic             start_nxt, update_nxt, err_ck_nxt, err_to_nxt, err_fail_nxt, latch_nxt, fail;
    logic signed [16:0] unused_sign;
    logic [15:0]      hum_p0, temp_p0;
    logic             vld_p0;

    assign done_edge   = sensor_done & ~done_q;
    assign cap         = (state_q == ST_WAIT_DONE) && done_edge;
    assign state       = state_q;
    assign unused_sign = '0;

    always_comb begin
        state_nxt         = state_q;
        gap_nxt           = gap_cnt;
        to_nxt            = to_cnt;
        period_nxt        = period_cnt;
        retry_nxt         = retry_cnt;
        req_pending_nxt   = req_pending;
        retry_pending_nxt = retry_pending;
        start_nxt         = 1'b0;
        update_nxt        = 1'b0;
        err_ck_nxt        = 1'b0;
        err_to_nxt        = 1'b0;
        err_fail_nxt      = 1'b0;
        latch_nxt         = 1'b0;
        fail              = 1'b0;

        if (tick && period_cnt != PERIOD_LAST)
            period_nxt = period_cnt + 1'b1;
        if (req && state_q != ST_IDLE)
            req_pending_nxt = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // periodic launch is qualified by the tick so start-to-start is a whole number of ms
                if (retry_pending || req || req_pending ||
                    (enable && tick && period_cnt == PERIOD_LAST)) begin
                    state_nxt         = ST_TRIG;
                    start_nxt         = 1'b1;
                    req_pending_nxt   = 1'b0;
                    retry_pending_nxt = 1'b0;
                end
            end
            ST_TRIG: begin
                to_nxt     = '0;
                period_nxt = '0;
                state_nxt  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_edge) begin
                    state_nxt = ST_EVAL;
                end else if (tick) begin
                    if (to_cnt == TO_LAST) begin
                        err_to_nxt = 1'b1;
                        fail       = 1'b1;
                    end else begin
                        to_nxt = to_cnt + 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                if (vld_p0) begin
                    latch_nxt  = 1'b1;
                    update_nxt = 1'b1;
                    retry_nxt  = '0;
                    state_nxt  = ST_HOLDOFF;
                end else begin
                    err_ck_nxt = 1'b1;
                    fail       = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_HOLDOFF;
        endcase

        if (fail) begin
            state_nxt = ST_HOLDOFF;
            if (retry_cnt < RTY_LAST) begin
                retry_nxt         = retry_cnt + 1'b1;
                retry_pending_nxt = 1'b1;
            end else begin
                err_fail_nxt      = 1'b1;
                retry_nxt         = '0;
                retry_pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLDOFF;
            gap_cnt       <= '0;
            to_cnt        <= '0;
            period_cnt    <= '0;
            retry_cnt     <= '0;
            req_pending   <= 1'b0;
            retry_pending <= 1'b0;
            done_q        <= 1'b0;
            vld_p0        <= 1'b0;
            rst_two       <= 1'b0;
            sensor_start  <= 1'b0;
            sensor_rst    <= 1'b0;
            humidity      <= '0;
            temperature   <= '0;
            data_valid    <= 1'b0;
            update        <= 1'b0;
            err_checksum  <= 1'b0;
            err_timeout   <= 1'b0;
            err_fail      <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state_q       <= state_nxt;
            gap_cnt       <= gap_nxt;
            to_cnt        <= to_nxt;
            period_cnt    <= period_nxt;
            retry_cnt     <= retry_nxt;
            req_pending   <= req_pending_nxt;
            retry_pending <= retry_pending_nxt;
            done_q        <= sensor_done;
            if (cap)
                vld_p0 <= sensor_valid;
            // sensor_rst is held for the watchdog cycle plus one more
            rst_two       <= err_to_nxt;
            sensor_rst    <= err_to_nxt | rst_two;
            sensor_start  <= start_nxt;
            update        <= update_nxt;
            err_checksum  <= err_ck_nxt;
            err_timeout   <= err_to_nxt;
            err_fail      <= err_fail_nxt;
            busy          <= (state_nxt != ST_IDLE);
            if (latch_nxt) begin
                humidity    <= hum_p0;
                temperature <= temp_p0;
                data_valid  <= 1'b1;
            end
        end
    end

    // Stage p0: raw reading captured on the done edge, evaluated in EVAL
    always_ff @(posedge clk) begin
        if (cap) begin
            hum_p0  <= sensor_hum;
            temp_p0 <= sensor_temp;
        end
    end

endmodule

// File: tb/tb_dht11_scheduler.sv
// Scoreboard bench for dht11_scheduler: a behavioural retry/latch model predicts the event
// stream, a sensor model answers start pulses, and a monitor checks every DUT event.
module tb_dht11_scheduler;

    localparam int CLK_HZ = 10_000;
    localparam int DIV    = 10;
    localparam int PER    = 20;
    localparam int GAP    = 5;
    localparam int TO     = 8;
    localparam int MAXR   = 2;

    localparam int EV_START = 0, EV_TO = 1, EV_CK = 2, EV_FAIL = 3, EV_UPD = 4;
    localparam int R_VALID = 0, R_BAD = 1, R_NONE = 2;

    typedef struct {
        int          kind;
        logic [15:0] hum;
        logic [15:0] temp;
        logic        dv;
    } ev_t;

    typedef struct {
        int          kind;
        logic [15:0] hum;
        logic [15:0] temp;
        int          dly;
    } plan_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, req;
    logic        sensor_start, sensor_rst, sensor_done, sensor_valid;
    logic [15:0] sensor_hum, sensor_temp, humidity, temperature;
    logic        data_valid, update, err_checksum, err_timeout, err_fail, busy;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rst_run = 0;
    int rst_pulses = 0;
    ev_t   exp_q[$];
    plan_t plan_q[$];
    int    st_times[$];
    int    to_times[$];

    logic [15:0] m_hum = '0, m_temp = '0;
    logic        m_dv = 1'b0;
    int          m_retry = 0;

    dht11_scheduler #(
        .CLK_HZ(CLK_HZ), .PERIOD_MS(PER), .MIN_GAP_MS(GAP), .TIMEOUT_MS(TO), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .sensor_start(sensor_start), .sensor_rst(sensor_rst),
        .sensor_done(sensor_done), .sensor_valid(sensor_valid),
        .sensor_hum(sensor_hum), .sensor_temp(sensor_temp),
        .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
        .update(update), .err_checksum(err_checksum), .err_timeout(err_timeout),
        .err_fail(err_fail), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic ev_t mk_ev(input int kind);
        ev_t e;
        e.kind = kind; e.hum = m_hum; e.temp = m_temp; e.dv = m_dv;
        return e;
    endfunction

    // Model: one attempt of the current request and the events the spec says it produces
    task automatic add_attempt(input int kind, input logic [15:0] h, input logic [15:0] t);
        plan_t p;
        p.kind = kind; p.hum = h; p.temp = t; p.dly = $urandom_range(30, 10);
        plan_q.push_back(p);
        exp_q.push_back(mk_ev(EV_START));
        if (kind == R_VALID) begin
            m_hum = h; m_temp = t; m_dv = 1'b1; m_retry = 0;
            exp_q.push_back(mk_ev(EV_UPD));
        end else begin
            exp_q.push_back(mk_ev(kind == R_NONE ? EV_TO : EV_CK));
            if (m_retry == MAXR) begin
                exp_q.push_back(mk_ev(EV_FAIL));
                m_retry = 0;
            end else begin
                m_retry++;
            end
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || humidity != e.hum || temperature != e.temp || data_valid != e.dv) begin
                n_fail++;
                $display("FAIL event: got kind=%0d H=%h T=%h dv=%b, expected kind=%0d H=%h T=%h dv=%b",
                         kind, humidity, temperature, data_valid, e.kind, e.hum, e.temp, e.dv);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_state"}, int'(state), 4);
        check({tag, "_outs"}, int'({humidity, temperature, data_valid, update, err_checksum,
                                    err_timeout, err_fail, sensor_start, sensor_rst} != '0), 0);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic wait_starts(input int n, input int limit);
        int k = 0;
        while (st_times.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", st_times.size(), n);
    endtask

    // Sensor model: answers each start according to the next queued plan
    initial begin
        plan_t p;
        sensor_done = 1'b0; sensor_valid = 1'b0; sensor_hum = '0; sensor_temp = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && sensor_start) begin
                if (plan_q.size() != 0) p = plan_q.pop_front();
                else p.kind = R_NONE;
                if (p.kind != R_NONE) begin
                    repeat (p.dly) @(negedge clk);
                    sensor_hum   = p.hum;
                    sensor_temp  = p.temp;
                    sensor_valid = (p.kind == R_VALID);
                    sensor_done  = 1'b1;
                    repeat (3) @(negedge clk);
                    sensor_done  = 1'b0;
                    sensor_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT event
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                rst_run = 0;
            end else begin
                if (sensor_start) begin st_times.push_back(cyc); check_ev(EV_START); end
                if (err_timeout)  begin to_times.push_back(cyc); check_ev(EV_TO); end
                if (err_checksum) check_ev(EV_CK);
                if (err_fail)     check_ev(EV_FAIL);
                if (update)       check_ev(EV_UPD);
                if (sensor_rst) begin
                    if (rst_run == 0) check("sensor_rst_with_timeout", int'(err_timeout), 1);
                    rst_run++;
                end else if (rst_run != 0) begin
                    check("sensor_rst_len", rst_run, 2);
                    rst_pulses++;
                    rst_run = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, rq, p0;
        rst_n = 1'b0; enable = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // 1: request at 6 ms after reset, one good read
        rst_n = 1'b1;
        rel = cyc;
        while (cyc < rel + 60) @(negedge clk);
        add_attempt(R_VALID, 16'h3700, 16'h1A00);
        st_times.delete();
        rq = cyc;
        pulse_req();
        wait_drain("t1", 200);
        check("t1_starts", st_times.size(), 1);
        check("t1_start_latency", st_times[0] - rq, 1);
        check("t1_humidity", int'(humidity), 16'h3700);
        check("t1_temperature", int'(temperature), 16'h1A00);

        // 2: invalid, invalid, valid
        wait_idle(100);
        st_times.delete();
        add_attempt(R_BAD, 16'($urandom), 16'($urandom));
        add_attempt(R_BAD, 16'($urandom), 16'($urandom));
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        pulse_req();
        wait_drain("t2", 600);
        check("t2_starts", st_times.size(), 3);
        check_rng("t2_gap1", st_times[1] - st_times[0], GAP * DIV, 1000);
        check_rng("t2_gap2", st_times[2] - st_times[1], GAP * DIV, 1000);

        // 3: three invalid reads after a good one exhaust the retries
        wait_idle(100);
        st_times.delete();
        for (int i = 0; i < 3; i++) add_attempt(R_BAD, 16'($urandom), 16'($urandom));
        pulse_req();
        wait_drain("t3", 600);
        check("t3_starts", st_times.size(), 3);
        check("t3_data_valid", int'(data_valid), 1);
        check("t3_humidity", int'(humidity), int'(m_hum));

        // 4: no done -> watchdog, sensor reset, retry after the gap
        wait_idle(100);
        st_times.delete(); to_times.delete();
        p0 = rst_pulses;
        add_attempt(R_NONE, 16'h0, 16'h0);
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        pulse_req();
        wait_drain("t4", 600);
        repeat (3) @(negedge clk);
        check("t4_timeouts", to_times.size(), 1);
        check_rng("t4_timeout_delay", to_times[0] - st_times[0], (TO - 1) * DIV + 1, TO * DIV + 1);
        check_rng("t4_retry_gap", st_times[1] - to_times[0], GAP * DIV, GAP * DIV + 2);
        check("t4_rst_pulses", rst_pulses - p0, 1);

        // 5: periodic mode, req while busy, req coinciding with the period launch
        wait_idle(100);
        st_times.delete();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        wait_drain("t5a", 1000);
        check("t5_period1", st_times[1] - st_times[0], PER * DIV);
        check("t5_period2", st_times[2] - st_times[1], PER * DIV);
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        wait_starts(4, 400);
        repeat (15) @(negedge clk);
        pulse_req();
        repeat (5) @(negedge clk);
        pulse_req();
        wait_drain("t5b", 600);
        check_rng("t5_extra_start", st_times[4] - st_times[3], GAP * DIV, 150);
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        wait_drain("t5c", 400);
        check_rng("t5_after_extra", st_times[5] - st_times[4], (PER - 1) * DIV + 1, PER * DIV + 1);
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        while (cyc < st_times[5] + PER * DIV - 1) @(negedge clk);
        pulse_req();
        wait_drain("t5d", 600);
        check("t5_req_on_period", st_times[6] - st_times[5], PER * DIV);
        check("t5_period_after_req", st_times[7] - st_times[6], PER * DIV);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        check("t5_no_launch_after_disable", st_times.size(), 8);

        // 6: reset during WAIT_DONE
        wait_idle(100);
        st_times.delete();
        add_attempt(R_NONE, 16'h0, 16'h0);
        pulse_req();
        wait_starts(1, 50);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        plan_q.delete(); exp_q.delete();
        m_hum = '0; m_temp = '0; m_dv = 1'b0; m_retry = 0;
        repeat (2) @(negedge clk);
        check_reset_state("t6");
        rst_n = 1'b1;
        rel = cyc;
        add_attempt(R_VALID, 16'($urandom), 16'($urandom));
        repeat (3) @(negedge clk);
        pulse_req();
        wait_drain("t6", 300);
        check("t6_starts", st_times.size(), 2);
        check_rng("t6_holdoff", st_times[1] - rel, GAP * DIV, GAP * DIV + 12);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
